// File: rtl/mips_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter_if
//
// Purpose:
//   Unified memory port of the MIPS core. It carries one valid/ready access
//   at a time from the arbiter (master) to the memory (slave).
//
// Signals:
//   mem_valid  master -> slave   access request
//   mem_we     master -> slave   1 = store, 0 = load/fetch
//   mem_addr   master -> slave   ADDR_W access address
//   mem_wdata  master -> slave   DATA_W store data
//   mem_be     master -> slave   DATA_W/8 byte enables
//   mem_ready  slave  -> master  memory accepts/completes the access this cycle
//   mem_rdata  slave  -> master  read data, valid when mem_valid & mem_ready
// ---------------------------------------------------------------------------
interface mips_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic                  mem_valid;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_ready;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_valid,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter
//
// Purpose:
//   Shares the single memory port between instruction fetch (read-only) and
//   data memory (load/store). One access is granted at a time; data accesses
//   win, except that fetch is granted once STARVE_LIM consecutive data grants
//   have been made while fetch was waiting. A granted access that sees no
//   mem_ready for TIMEOUT cycles is aborted with 32'hDEADBEEF and a sticky err.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   if_req/if_addr             fetch request, held until if_done
//   if_rdata/if_done           fetch read data and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_be             data request, held until dm_done
//   dm_rdata/dm_done           load data and one-cycle completion pulse
//   mem                        memory port (master side of mips_mem_arbiter_if)
//   stall_if/stall_dm          pipeline stalls, req & ~done
//   err                        sticky wait-state timeout flag
//
// State table:
//   state  | meaning
//   IDLE   | arbitrate between pending requests
//   GNT_IF | fetch access presented on mem port, waiting for mem_ready
//   GNT_DM | data access presented on mem port, waiting for mem_ready
//   RESP   | winner's done pulse; requests ignored; always back to IDLE
// ---------------------------------------------------------------------------
module mips_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_done,

    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_be,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_done,

    mips_mem_arbiter_if.master    mem,

    output logic                  stall_if,
    output logic                  stall_dm,
    output logic                  err
);

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    // wait_cnt only has to reach TIMEOUT-1
    localparam int WW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [SW-1:0]     STREAK_MAX = SW'(STARVE_LIM);
    localparam logic [WW-1:0]     WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [SW-1:0]       streak_q,    streak_d;
    logic [WW-1:0]       wait_cnt_q,  wait_cnt_d;

    logic                mem_valid_q, mem_valid_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q,    mem_be_d;

    logic                if_done_q,   if_done_d;
    logic                dm_done_q,   dm_done_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
    logic                err_q,       err_d;

    logic                grant_dm;
    logic                grant_if;
    logic                finish;
    logic [DATA_W-1:0]   resp_data;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            wait_cnt_q  <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        wait_cnt_d  = wait_cnt_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        err_d       = err_q;
        grant_dm    = 1'b0;
        grant_if    = 1'b0;
        finish      = 1'b0;
        resp_data   = mem.mem_rdata;

        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                // Data wins unless fetch has already waited through
                // STARVE_LIM consecutive data grants.
                grant_dm = dm_req && !(if_req && (streak_q == STREAK_MAX));
                grant_if = if_req && !grant_dm;

                if (grant_dm) begin
                    state_d     = GNT_DM;
                    mem_valid_d = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_be_d    = dm_be;
                    if (if_req) begin
                        streak_d = (streak_q == STREAK_MAX) ? streak_q
                                                            : streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                end else if (grant_if) begin
                    state_d     = GNT_IF;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                    streak_d    = '0;
                end
            end

            GNT_IF, GNT_DM: begin
                // mem_ready is checked first so a response landing on the
                // timeout cycle completes normally.
                if (mem.mem_ready) begin
                    finish    = 1'b1;
                    resp_data = mem.mem_rdata;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    finish    = 1'b1;
                    resp_data = ABORT_DATA;
                    err_d     = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end

                if (finish) begin
                    state_d     = RESP;
                    mem_valid_d = 1'b0;
                    wait_cnt_d  = '0;
                    if (state_q == GNT_DM) begin
                        dm_rdata_d = resp_data;
                        dm_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = resp_data;
                        if_done_d  = 1'b1;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign mem.mem_valid = mem_valid_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_be    = mem_be_q;

    assign if_done  = if_done_q;
    assign dm_done  = dm_done_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign err      = err_q;

    assign stall_if = if_req & ~if_done_q;
    assign stall_dm = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_mem_arbiter
//
// Self-checking bench for mips_mem_arbiter. A small memory model answers
// after a programmable number of wait states (or never) with data derived
// from the address. Each request pushes its expected completion onto a
// scoreboard queue; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_mips_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BE_W       = DATA_W / 8;
    localparam int STARVE_LIM = 4;
    localparam int TIMEOUT    = 8;

    logic                clk;
    logic                rst_n;
    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic [DATA_W-1:0]   if_rdata;
    logic                if_done;
    logic                dm_req;
    logic                dm_we;
    logic [ADDR_W-1:0]   dm_addr;
    logic [DATA_W-1:0]   dm_wdata;
    logic [BE_W-1:0]     dm_be;
    logic [DATA_W-1:0]   dm_rdata;
    logic                dm_done;
    logic                stall_if;
    logic                stall_dm;
    logic                err;

    mips_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    mips_mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_LIM (STARVE_LIM),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_be    (dm_be),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .mem      (mem_bus),
        .stall_if (stall_if),
        .stall_dm (stall_dm),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic              is_dm;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    // Memory model
    logic [DATA_W-1:0] mem_base  = 32'h1234_5678;
    int                mem_wait  = 0;
    bit                mem_never = 1'b0;
    int                vcnt      = 0;

    assign mem_bus.mem_ready = mem_bus.mem_valid && !mem_never && (vcnt == mem_wait);
    assign mem_bus.mem_rdata = mem_bus.mem_valid ? (mem_base ^ mem_bus.mem_addr) : '0;

    always @(posedge clk) begin
        if (mem_bus.mem_valid && !mem_bus.mem_ready) vcnt <= vcnt + 1;
        else                                         vcnt <= 0;
    end

    function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
        return mem_base ^ a;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t              e;
        logic [DATA_W-1:0] got;
        if (rst_n && (if_done || dm_done)) begin
            checks++;
            if (if_done && dm_done) begin
                errors++;
                $display("FAIL sb_both_done: if_done=%0b dm_done=%0b, required one only", if_done, dm_done);
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: done pulse if=%0b dm=%0b with empty scoreboard", if_done, dm_done);
            end else begin
                e   = exp_q.pop_front();
                got = e.is_dm ? dm_rdata : if_rdata;
                if (dm_done !== e.is_dm) begin
                    errors++;
                    $display("FAIL sb_winner: got dm_done=%0b, required is_dm=%0b", dm_done, e.is_dm);
                end
                checks++;
                if (got !== e.data) begin
                    errors++;
                    $display("FAIL sb_rdata: got %h, required %h", got, e.data);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        checks++;
        if ({mem_bus.mem_valid, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_be} !== '0) begin
            errors++;
            $display("FAIL reset_mem: valid=%0b we=%0b addr=%h wdata=%h be=%h, required all 0",
                     mem_bus.mem_valid, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_be);
        end
        checks++;
        if ({if_done, dm_done, err, stall_if, stall_dm} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: if_done=%0b dm_done=%0b err=%0b stall_if=%0b stall_dm=%0b, required 0",
                     if_done, dm_done, err, stall_if, stall_dm);
        end
        checks++;
        if ({if_rdata, dm_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_rdata: if_rdata=%h dm_rdata=%h, required 0", if_rdata, dm_rdata);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single_load;
        mem_base = 32'h1234_5678;
        mem_wait = 0;
        dm_we    = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;
        dm_be    = 4'hF;
        dm_req   = 1'b1;
        exp_q.push_back(exp_t'{1'b1, model_rd(32'h0)});
        tick;
        checks++;
        if (mem_bus.mem_valid !== 1'b1 || mem_bus.mem_we !== 1'b0 || stall_dm !== 1'b1) begin
            errors++;
            $display("FAIL load_c1: valid=%0b we=%0b stall_dm=%0b, required 1 0 1",
                     mem_bus.mem_valid, mem_bus.mem_we, stall_dm);
        end
        tick;
        checks++;
        if (dm_done !== 1'b1 || dm_rdata !== 32'h1234_5678 || stall_dm !== 1'b0) begin
            errors++;
            $display("FAIL load_c2: dm_done=%0b dm_rdata=%h stall_dm=%0b, required 1 12345678 0",
                     dm_done, dm_rdata, stall_dm);
        end
        dm_req = 1'b0;
        tick;
        checks++;
        if (dm_done !== 1'b0 || mem_bus.mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_c3: dm_done=%0b mem_valid=%0b, required 0 0", dm_done, mem_bus.mem_valid);
        end
    endtask

    task automatic test_store_wait;
        int bad_fields;
        bad_fields = 0;
        mem_base = 32'hA5A5_0F0F;
        mem_wait = 3;
        dm_we    = 1'b1;
        dm_addr  = 32'h200;
        dm_wdata = 32'hCAFE_F00D;
        dm_be    = 4'b0011;
        dm_req   = 1'b1;
        exp_q.push_back(exp_t'{1'b1, model_rd(32'h200)});
        for (int c = 1; c <= 4; c++) begin
            tick;
            if ({mem_bus.mem_valid, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_be, dm_done}
                !== {1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, 4'b0011, 1'b0}) bad_fields++;
        end
        checks++;
        if (bad_fields != 0) begin
            errors++;
            $display("FAIL store_fields: %0d of 4 wait cycles had wrong mem fields, required 0", bad_fields);
        end
        tick;
        checks++;
        if (dm_done !== 1'b1 || err !== 1'b0 || mem_bus.mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_done: dm_done=%0b err=%0b mem_valid=%0b at cycle 5, required 1 0 0",
                     dm_done, err, mem_bus.mem_valid);
        end
        dm_req = 1'b0;
        tick;
    endtask

    task automatic test_fetch_stream;
        int                n_done;
        int                last_done;
        int                c;
        int                bad;
        logic [ADDR_W-1:0] a;
        n_done = 0; last_done = -1; c = 0; bad = 0; a = '0;
        mem_base = 32'h0BAD_F00D;
        mem_wait = 0;
        if_addr  = a;
        if_req   = 1'b1;
        exp_q.push_back(exp_t'{1'b0, model_rd(a)});
        while (n_done < 3 && c < 40) begin
            tick;
            c++;
            if (mem_bus.mem_valid) begin
                checks++;
                if (mem_bus.mem_be !== 4'hF || mem_bus.mem_we !== 1'b0 || mem_bus.mem_addr !== a || mem_bus.mem_wdata !== '0) begin
                    errors++;
                    $display("FAIL fetch_fields: be=%h we=%0b addr=%h wdata=%h, required f 0 %h 0",
                             mem_bus.mem_be, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, a);
                end
            end
            if (if_done) begin
                n_done++;
                checks++;
                if ((last_done < 0 && c != 2) || (last_done >= 0 && c - last_done != 3)) begin
                    errors++;
                    $display("FAIL fetch_spacing: if_done at cycle %0d, previous %0d, required 2 then every 3", c, last_done);
                end
                last_done = c;
                if (n_done < 3) begin
                    a += 4;
                    if_addr = a;
                    exp_q.push_back(exp_t'{1'b0, model_rd(a)});
                end else begin
                    if_req = 1'b0;
                end
            end
        end
        checks++;
        if (n_done != 3) begin
            errors++;
            if_req = 1'b0;
            $display("FAIL fetch_timeout: %0d fetches completed, required 3", n_done);
        end
        tick;
    endtask

    task automatic test_starvation;
        int n_dm;
        int n_if;
        int c;
        n_dm = 0; n_if = 0; c = 0;
        mem_base = 32'h5555_AAAA;
        mem_wait = 0;
        dm_we    = 1'b0;
        dm_addr  = 32'h2000;
        dm_wdata = '0;
        dm_be    = 4'hF;
        if_addr  = 32'h1000;
        for (int k = 0; k < 4; k++) exp_q.push_back(exp_t'{1'b1, model_rd(32'h2000)});
        exp_q.push_back(exp_t'{1'b0, model_rd(32'h1000)});
        exp_q.push_back(exp_t'{1'b1, model_rd(32'h2000)});
        dm_req = 1'b1;
        if_req = 1'b1;
        while ((n_dm < 5 || n_if < 1) && c < 60) begin
            tick;
            c++;
            checks++;
            if (stall_if !== (if_req & ~if_done)) begin
                errors++;
                $display("FAIL starve_stall_if: stall_if=%0b at cycle %0d, required %0b", stall_if, c, if_req & ~if_done);
            end
            if (if_done) begin
                n_if++;
                checks++;
                if (n_dm != 4) begin
                    errors++;
                    $display("FAIL starve_order: if_done after %0d dm_done, required 4", n_dm);
                end
                if_req = 1'b0;
            end
            if (dm_done) begin
                n_dm++;
                if (n_dm == 5) dm_req = 1'b0;
            end
        end
        checks++;
        if (n_dm != 5 || n_if != 1 || c != 17) begin
            errors++;
            $display("FAIL starve_total: dm=%0d if=%0d last done cycle %0d, required 5 1 17", n_dm, n_if, c);
        end
        dm_req = 1'b0;
        if_req = 1'b0;
        tick;
    endtask

    // mem_ready lands on the last allowed wait cycle: normal completion
    task automatic test_timeout_boundary;
        int  nval;
        int  c;
        bit  got_done;
        nval = 0; c = 0; got_done = 1'b0;
        mem_base = 32'h0F0F_3C3C;
        mem_wait = TIMEOUT - 1;
        dm_we    = 1'b0;
        dm_addr  = 32'h300;
        dm_be    = 4'hF;
        dm_req   = 1'b1;
        exp_q.push_back(exp_t'{1'b1, model_rd(32'h300)});
        while (!got_done && c < 20) begin
            tick;
            c++;
            if (mem_bus.mem_valid) nval++;
            if (dm_done) got_done = 1'b1;
        end
        checks++;
        if (!got_done || nval != TIMEOUT || c != TIMEOUT + 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_boundary: done=%0b valid_cycles=%0d done_cycle=%0d err=%0b, required 1 %0d %0d 0",
                     got_done, nval, c, err, TIMEOUT, TIMEOUT + 1);
        end
        dm_req = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        int  nval;
        int  c;
        bit  got_done;
        nval = 0; c = 0; got_done = 1'b0;
        mem_never = 1'b1;
        dm_we     = 1'b0;
        dm_addr   = 32'h304;
        dm_be     = 4'hF;
        dm_req    = 1'b1;
        exp_q.push_back(exp_t'{1'b1, 32'hDEAD_BEEF});
        while (!got_done && c < 20) begin
            tick;
            c++;
            if (mem_bus.mem_valid) nval++;
            if (dm_done) got_done = 1'b1;
        end
        checks++;
        if (!got_done || nval != TIMEOUT || c != TIMEOUT + 1) begin
            errors++;
            $display("FAIL tmo_len: done=%0b valid_cycles=%0d done_cycle=%0d, required 1 %0d %0d",
                     got_done, nval, c, TIMEOUT, TIMEOUT + 1);
        end
        checks++;
        if (dm_rdata !== 32'hDEAD_BEEF || err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_abort: dm_rdata=%h err=%0b, required deadbeef 1", dm_rdata, err);
        end
        dm_req = 1'b0;
        tick;
        mem_never = 1'b0;
        mem_wait  = 0;
        if_addr   = 32'h40;
        if_req    = 1'b1;
        exp_q.push_back(exp_t'{1'b0, model_rd(32'h40)});
        got_done = 1'b0;
        c = 0;
        while (!got_done && c < 10) begin
            tick;
            c++;
            if (if_done) got_done = 1'b1;
        end
        if_req = 1'b0;
        tick;
        checks++;
        if (!got_done || err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: fetch done=%0b err=%0b after good access, required 1 1", got_done, err);
        end
    endtask

    task automatic test_reset_mid;
        mem_never = 1'b1;
        mem_wait  = 0;
        dm_we     = 1'b0;
        dm_addr   = 32'h500;
        dm_be     = 4'hF;
        dm_req    = 1'b1;
        tick;
        tick;
        tick;
        checks++;
        if (mem_bus.mem_valid !== 1'b1 || dm_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pre: mem_valid=%0b dm_done=%0b in wait state, required 1 0", mem_bus.mem_valid, dm_done);
        end
        rst_n   = 1'b0;
        dm_req  = 1'b0;
        if_addr = 32'h80;
        if_req  = 1'b1;
        tick;
        checks++;
        if ({mem_bus.mem_valid, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_be,
             if_done, dm_done, if_rdata, dm_rdata, err} !== '0) begin
            errors++;
            $display("FAIL rstmid_zero: valid=%0b addr=%h be=%h if_done=%0b dm_done=%0b if_rdata=%h dm_rdata=%h err=%0b, required all 0",
                     mem_bus.mem_valid, mem_bus.mem_addr, mem_bus.mem_be, if_done, dm_done, if_rdata, dm_rdata, err);
        end
        rst_n     = 1'b1;
        mem_never = 1'b0;
        exp_q.push_back(exp_t'{1'b0, model_rd(32'h80)});
        tick;
        checks++;
        if (mem_bus.mem_valid !== 1'b1 || mem_bus.mem_addr !== 32'h80 || dm_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_grant: mem_valid=%0b addr=%h dm_done=%0b, required 1 80 0",
                     mem_bus.mem_valid, mem_bus.mem_addr, dm_done);
        end
        tick;
        checks++;
        if (if_done !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_done: if_done=%0b at cycle 2 after release, required 1", if_done);
        end
        if_req = 1'b0;
        tick;
    endtask

    initial begin
        rst_n    = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        dm_be    = '0;

        test_reset;
        test_single_load;
        test_store_wait;
        test_fetch_stream;
        test_starvation;
        test_timeout_boundary;
        test_timeout;
        test_reset_mid;

        tick;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected completions never seen, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Shares the single unified memory port of the MIPS core between the instruction-fetch requester (read-only) and the data-memory requester (load/store). Grants one transaction at a time over a valid/ready memory handshake with variable wait states. Returns read data and a one-cycle done pulse to the winning requester, and supplies per-requester stall signals to the pipeline. Data accesses have priority, with a starvation guard for fetch and a wait-state timeout.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 bits)
- STARVE_LIM, 4, consecutive data grants allowed while fetch waits
- TIMEOUT, 255, max cycles a granted access waits for mem_ready

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- if_req  in  1  fetch request; held with if_addr stable until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch data; valid when if_done=1
- if_done  out  1  one-cycle completion pulse
- dm_req  in  1  data request; held with fields stable until dm_done
- dm_we  in  1  1=store, 0=load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_be  in  DATA_W/8  byte enables
- dm_rdata  out  DATA_W  load data; valid when dm_done=1
- dm_done  out  1  one-cycle completion pulse
- mem_valid  out  1  access request to memory
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered copy of the granted requester's fields (fetch: we=0, be=all ones, wdata=0)
- mem_ready  in  1  memory accepts/completes the access this cycle
- mem_rdata  in  DATA_W  read data; valid when mem_valid & mem_ready
- stall_if  out  1  if_req & ~if_done (combinational)
- stall_dm  out  1  dm_req & ~dm_done (combinational)
- err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, GNT_IF, GNT_DM, RESP.
- IDLE: arbitration.
  - dm_req only -> GNT_DM.
  - if_req only -> GNT_IF.
  - Both -> GNT_DM, unless streak==STARVE_LIM, in which case GNT_IF.
  - Neither -> stay in IDLE.
- Streak counter (0..STARVE_LIM):
  - Increments on a DM grant made while if_req=1.
  - Clears on any IF grant and on a DM grant made while if_req=0.
- GNT_x:
  - mem_valid=1; mem_* fields are latched on entry and held stable.
  - wait_cnt counts cycles spent in the state.
  - mem_ready=1 -> capture mem_rdata into the winner's rdata register, go to RESP.
  - wait_cnt reaches TIMEOUT-1 with mem_ready=0 -> abort: rdata register = 32'hDEADBEEF, err set, go to RESP.
- RESP:
  - The winner's done pulses for exactly one cycle; mem_valid=0.
  - Next state is always IDLE.
  - Requests are ignored during RESP. A requester must drop req, or present a new request, at the edge ending its done cycle.
- Loser requests remain pending; the pipeline sees stall_x=1 throughout.
- if_rdata and dm_rdata hold their last captured value between transactions.
- err clears only on reset.

## Timing
- Reset (rst_n=0 sampled at an edge) forces:
  - state=IDLE, streak=0, wait_cnt=0.
  - mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - if_done=0, dm_done=0, if_rdata=0, dm_rdata=0, err=0.
- Reset mid-transaction: the access is dropped, no done pulse is issued, and mem_valid is 0 from the first cycle after the reset edge.
- Latency: request seen in IDLE at cycle 0, mem_valid at cycle 1.
  - Zero-wait memory (mem_ready=1 at cycle 1): done at cycle 2, next arbitration at cycle 3.
  - Each wait state adds one cycle.
- Minimum back-to-back spacing: 3 cycles per transaction.
- Timeout: mem_valid is high for exactly TIMEOUT cycles, then done follows in the next cycle.
- mem_ready while mem_valid=0 is ignored.
- mem_ready arriving on the same cycle as the timeout: mem_ready wins, with no error.

## Test plan
- Single load, zero-wait, mem_rdata=0x12345678 -> mem_valid at cycle 1 with mem_we=0; dm_done and dm_rdata=0x12345678 at cycle 2; stall_dm low from cycle 2.
- Store with 3 wait states, dm_be=4'b0011 -> mem_valid high for 4 cycles with fields stable; dm_done at cycle 5; err=0.
- Both requesters asserted simultaneously, dm_req reasserted after every done, STARVE_LIM=4 -> grant order DM,DM,DM,DM,IF,DM...; if_done after the 4th dm_done.
- Memory never ready, TIMEOUT=8 -> mem_valid high for 8 cycles; done pulse with rdata=0xDEADBEEF; err=1 and stays 1 through later successful transactions.
- rst_n low during GNT_DM wait state -> next cycle all outputs 0, no dm_done; after release, a pending if_req is granted from IDLE with 2-cycle latency.
- Fetch-only stream, zero-wait, addresses 0x0,0x4,0x8 -> if_done every 3 cycles; mem_be=4'hF and mem_we=0 on each access.
